// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame FSM; parity support built only with UART_RX_PARITY_EN
module uart_rx_frame_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [4:0] prescale,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic       sampled_bit,
    output logic [4:0] edge_count,
    output logic       dat_samp_en,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state, state_n;
    logic [4:0] ps_q;
    logic [2:0] bit_idx;
    logic [7:0] shift_q;
    logic       par_fail;
    logic       stop_fail;
    logic       done_q;
    logic       legal_ps;
    logic       bit_end;
    logic       start_frame;
    logic       finish;

    assign legal_ps    = (prescale == 5'd7) || (prescale == 5'd15) || (prescale == 5'd31);
    assign bit_end     = (state != IDLE) && (edge_count == ps_q);
    assign dat_samp_en = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_fail  <= 1'b0;
        end else if (start_frame) begin
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_fail  <= 1'b0;
        end else if (state == PARITY && bit_end &&
                     sampled_bit != (^shift_q ^ par_typ_q)) begin
            par_fail  <= 1'b1;
        end
    end

    assign par_err = done_q & par_fail;
`else
    logic unused_cfg;
    assign unused_cfg = par_en ^ par_typ;
    assign par_fail   = 1'b0;
    assign par_err    = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_in && legal_ps) begin
                    state_n     = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                // A high start sample is a line glitch; drop back silently.
                if (bit_end)
                    state_n = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = par_en_q ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end)
                    state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q       <= 5'd0;
            edge_count <= 5'd0;
            bit_idx    <= 3'd0;
            shift_q    <= 8'h00;
            stop_fail  <= 1'b0;
            done_q     <= 1'b0;
            p_data     <= 8'h00;
        end else begin
            done_q     <= finish;
            edge_count <= (state == IDLE || bit_end) ? 5'd0 : edge_count + 5'd1;
            if (start_frame) begin
                ps_q      <= prescale;
                bit_idx   <= 3'd0;
                stop_fail <= 1'b0;
            end
            if (state == DATA && bit_end) begin
                shift_q <= {sampled_bit, shift_q[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (finish) begin
                stop_fail <= ~sampled_bit;
                // Only clean frames overwrite the held byte.
                if (sampled_bit && !par_fail)
                    p_data <= shift_q;
            end
        end
    end

    assign data_valid = done_q & ~par_fail & ~stop_fail;
    assign stp_err    = done_q & stop_fail;

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-low reset).
REQ-002 rx_in  input  1  raw serial line, idle high.
REQ-003 prescale  input  5  oversampling ratio minus one; legal values 7, 15, 31.
REQ-004 par_en  input  1  parity bit present in frame when 1.
REQ-005 par_typ  input  1  parity type, 0 = even, 1 = odd.
REQ-006 sampled_bit  input  1  majority-voted bit from the data sampler, valid only in the cycle where edge_count == latched prescale.
REQ-007 edge_count  output  5  oversample edge index within the current bit, driven to the data sampler.
REQ-008 dat_samp_en  output  1  data sampler enable.
REQ-009 p_data  output  8  received byte.
REQ-010 data_valid  output  1  one-cycle strobe; p_data is valid.
REQ-011 par_err  output  1  one-cycle parity error strobe.
REQ-012 stp_err  output  1  one-cycle stop bit error strobe.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE: edge_count = 0, dat_samp_en = 0; if rx_in == 0 and prescale is 7, 15 or 31, latch prescale, par_en and par_typ, and go to START.
REQ-015 In IDLE, an illegal prescale SHALL keep the FSM in IDLE and ignore rx_in.
REQ-016 In all non-IDLE states, dat_samp_en = 1 and edge_count increments by 1 per clock from 0 up to latched prescale, then wraps to 0; a "bit end" is the cycle where edge_count == latched prescale.
REQ-017 START bit end: sampled_bit == 0 -> DATA with bit index 0; sampled_bit == 1 -> IDLE (glitch, no error strobe).
REQ-018 DATA bit end: shift sampled_bit into an internal 8-bit register, LSB first; after the 8th bit -> PARITY if latched par_en, else STOP.
REQ-019 PARITY bit end: expected = XOR of 8 data bits (even) or its inverse (odd); on mismatch set an internal parity-fail flag; -> STOP.
REQ-020 STOP bit end: sampled_bit == 0 sets stop-fail; -> IDLE.
REQ-021 The cycle after STOP bit end: par_err = parity-fail, stp_err = stop-fail, and data_valid = 1 only if neither flag is set; each is high for exactly one cycle.
REQ-022 p_data SHALL update only when data_valid is asserted and otherwise hold its value, including after error frames.
REQ-023 Internal fail flags SHALL clear on entry to START.
REQ-024 rx_in is not examined outside IDLE; the earliest next frame start is detected in the first IDLE cycle after a STOP bit end.
REQ-025 Input changes to prescale, par_en and par_typ during a frame SHALL have no effect until the next IDLE-to-START transition.

Reset
REQ-026 rst low SHALL force IDLE immediately, including mid-frame, and drive edge_count = 0, dat_samp_en = 0, p_data = 8'h00, and data_valid, par_err and stp_err = 0; it SHALL also clear the bit index, shift register, fail flags and latched configuration.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, PARITY state and par_err SHALL behave as specified above.
REQ-028 Without UART_RX_PARITY_EN, par_en and par_typ SHALL be ignored, DATA SHALL go directly to STOP, the PARITY state SHALL not exist, and par_err SHALL be tied to 0.

Verification
REQ-029 prescale = 7, par_en = 0, frame 0x55 with stop = 1 -> data_valid for one cycle, p_data = 8'h55, par_err = stp_err = 0; frame spans 80 clocks from START entry to data_valid.
REQ-030 prescale = 15, par_en = 1, par_typ = 0, byte 0xA3 with parity bit 0 -> data_valid, p_data = 8'hA3; same frame with parity bit 1 -> par_err pulse, no data_valid, p_data unchanged.
REQ-031 prescale = 31, byte 0x0F, stop bit 0 -> stp_err pulse, data_valid = 0.
REQ-032 rx_in low for 2 clocks, then high; sampled_bit = 1 at START bit end -> return to IDLE, no strobes.
REQ-033 prescale = 9, rx_in low -> remains in IDLE, dat_samp_en = 0; assert rst during DATA bit 4 -> all outputs 0 in the same cycle, IDLE.
REQ-034 Two back-to-back frames 0x12 then 0x34 with prescale = 7 -> two data_valid pulses with the correct p_data values.
